// File: rtl/stack_if.sv
// Command/response channel between the control unit (master) and stack_ctrl (slave).
interface stack_if #(parameter int N = 8);
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [N-1:0] req_data;
  logic         rsp_valid;
  logic         rsp_err;
  logic [N-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_data,
    input  req_ready, rsp_valid, rsp_err, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_data,
    output req_ready, rsp_valid, rsp_err, rsp_data
  );
endinterface

// File: rtl/stack_ctrl.sv
// Push/pop/peek/clear sequencer driving the SP control code and a synchronous stack RAM.
// Optional STACK_WATERMARK_EN adds a registered max_depth high-water output.
module stack_ctrl #(
    parameter int N        = 8,
    parameter int SP_INIT  = 128,
    parameter int SP_LIMIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    stack_if.slave       bus,
    output logic [1:0]   sp_ctrl,
    output logic [N-1:0] sp,
    output logic         full,
    output logic         empty,
    output logic [N-1:0] mem_addr,
    output logic         mem_we,
    output logic         mem_re,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] mem_rdata
`ifdef STACK_WATERMARK_EN
    ,
    output logic [N-1:0] max_depth
`endif
);

    localparam logic [N-1:0] INIT_V  = N'(SP_INIT);
    localparam logic [N-1:0] LIMIT_V = N'(SP_LIMIT);

    typedef enum logic [1:0] {
        OP_PEEK  = 2'b00,
        OP_PUSH  = 2'b01,
        OP_POP   = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        SPC_HOLD  = 2'b00,
        SPC_CLEAR = 2'b01,
        SPC_INC   = 2'b10,
        SPC_DEC   = 2'b11
    } spc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_READ,
        S_RESP,
        S_ERR,
        S_CLR
    } state_t;

    state_t       state;
    logic         is_pop;
    logic         rsp_valid_q;
    logic         rsp_err_q;
    logic [N-1:0] rsp_hold;

    assign full          = (sp == LIMIT_V);
    assign empty         = (sp == INIT_V);
    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    // RAM data arrives in RESP; outside it the last popped/peeked value is held.
    assign bus.rsp_data  = (state == S_RESP) ? mem_rdata : rsp_hold;

    // NOTE: async reset clears every register so an in-flight push loses its write strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sp          <= INIT_V;
            sp_ctrl     <= SPC_HOLD;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_hold    <= '0;
            is_pop      <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here turn every strobe into a one-cycle pulse.
            sp_ctrl     <= SPC_HOLD;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        case (op_t'(bus.req_op))
                            OP_PUSH: begin
                                if (full) begin
                                    state       <= S_ERR;
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                end else begin
                                    state       <= S_PUSH;
                                    mem_addr    <= sp - 1'b1;
                                    mem_wdata   <= bus.req_data;
                                    mem_we      <= 1'b1;
                                    sp_ctrl     <= SPC_DEC;
                                    rsp_valid_q <= 1'b1;
                                end
                            end
                            OP_POP, OP_PEEK: begin
                                if (empty) begin
                                    state       <= S_ERR;
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                end else begin
                                    state    <= S_READ;
                                    mem_addr <= sp;
                                    mem_re   <= 1'b1;
                                    is_pop   <= (bus.req_op == OP_POP);
                                    sp_ctrl  <= (bus.req_op == OP_POP) ? SPC_INC : SPC_HOLD;
                                end
                            end
                            OP_CLEAR: begin
                                state       <= S_CLR;
                                sp_ctrl     <= SPC_CLEAR;
                                rsp_valid_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_PUSH: begin
                    sp    <= sp - 1'b1;
                    state <= S_IDLE;
                end
                S_READ: begin
                    if (is_pop) sp <= sp + 1'b1;
                    rsp_valid_q <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    rsp_hold <= mem_rdata;
                    state    <= S_IDLE;
                end
                S_ERR: state <= S_IDLE;
                S_CLR: begin
                    sp    <= INIT_V;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef STACK_WATERMARK_EN
    // Depth after the push completes; clear leaves the high-water mark alone.
    logic [N-1:0] depth_next;
    assign depth_next = INIT_V - (sp - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_depth <= '0;
        end else if (state == S_PUSH && depth_next > max_depth) begin
            max_depth <= depth_next;
        end
    end
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: default instance (SP_INIT=128) and a small one (SP_INIT=4).
module tb_stack_ctrl;
    localparam int N = 8;
    localparam logic [1:0] OP_PEEK = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_CLEAR = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_if #(N) ba ();
    stack_if #(N) bb ();

    logic [1:0]   spc_a, spc_b;
    logic [N-1:0] sp_a, sp_b, addr_a, addr_b, wdata_a, wdata_b, rdata_a, rdata_b;
    logic         full_a, full_b, empty_a, empty_b, we_a, we_b, re_a, re_b;
`ifdef STACK_WATERMARK_EN
    logic [N-1:0] maxd_a, maxd_b;
`endif

    stack_ctrl #(.N(N), .SP_INIT(128), .SP_LIMIT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ba.slave),
        .sp_ctrl(spc_a), .sp(sp_a), .full(full_a), .empty(empty_a),
        .mem_addr(addr_a), .mem_we(we_a), .mem_re(re_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a)
`ifdef STACK_WATERMARK_EN
        , .max_depth(maxd_a)
`endif
    );

    stack_ctrl #(.N(N), .SP_INIT(4), .SP_LIMIT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bb.slave),
        .sp_ctrl(spc_b), .sp(sp_b), .full(full_b), .empty(empty_b),
        .mem_addr(addr_b), .mem_we(we_b), .mem_re(re_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b)
`ifdef STACK_WATERMARK_EN
        , .max_depth(maxd_b)
`endif
    );

    // Synchronous RAM models: read data appears the cycle after mem_re.
    logic [N-1:0] ram_a [256];
    logic [N-1:0] ram_b [256];
    always @(posedge clk) begin
        if (we_a) ram_a[addr_a] <= wdata_a;
        if (re_a) rdata_a <= ram_a[addr_a];
        if (we_b) ram_b[addr_b] <= wdata_b;
        if (re_b) rdata_b <= ram_b[addr_b];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         err;
        logic [N-1:0] data;
        logic         chk_data;
        int unsigned  cyc;
        string        name;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitors: pop the oldest expectation whenever a strobe appears.
    always @(negedge clk) begin
        if (ba.rsp_valid) begin
            if (q_a.size() == 0) check("a unexpected rsp_valid", 32'd1, 32'd0);
            else begin
                e_a = q_a.pop_front();
                check({e_a.name, " err"}, {31'd0, ba.rsp_err}, {31'd0, e_a.err});
                check({e_a.name, " latency"}, cyc, e_a.cyc);
                if (e_a.chk_data) check({e_a.name, " data"}, {24'd0, ba.rsp_data}, {24'd0, e_a.data});
            end
        end
        if (bb.rsp_valid) begin
            if (q_b.size() == 0) check("b unexpected rsp_valid", 32'd1, 32'd0);
            else begin
                e_b = q_b.pop_front();
                check({e_b.name, " err"}, {31'd0, bb.rsp_err}, {31'd0, e_b.err});
                check({e_b.name, " latency"}, cyc, e_b.cyc);
                if (e_b.chk_data) check({e_b.name, " data"}, {24'd0, bb.rsp_data}, {24'd0, e_b.data});
            end
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after acceptance.
    task automatic issue(input bit b, input logic [1:0] op, input logic [N-1:0] d,
                         input logic err, input logic [N-1:0] exp_d, input string name);
        exp_t e;
        int   n = 0;
        while (!(b ? bb.req_ready : ba.req_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({name, " ready timeout"}, 32'd0, 32'd1);
        if (b) begin
            bb.req_valid = 1'b1; bb.req_op = op; bb.req_data = d;
        end else begin
            ba.req_valid = 1'b1; ba.req_op = op; ba.req_data = d;
        end
        e.err      = err;
        e.data     = exp_d;
        e.chk_data = !err && (op == OP_POP || op == OP_PEEK);
        e.cyc      = cyc + ((err || op == OP_PUSH || op == OP_CLEAR) ? 1 : 2);
        e.name     = name;
        if (b) q_b.push_back(e);
        else q_a.push_back(e);
        @(negedge clk);
        if (b) bb.req_valid = 1'b0;
        else ba.req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ba.req_valid = 1'b0; ba.req_op = 2'b00; ba.req_data = '0;
        bb.req_valid = 1'b0; bb.req_op = 2'b00; bb.req_data = '0;
        for (int i = 0; i < 256; i++) begin
            ram_a[i] = '0;
            ram_b[i] = '0;
        end
        rdata_a = '0;
        rdata_b = '0;

        repeat (2) @(negedge clk);
        check("reset sp", {24'd0, sp_a}, 32'd128);
        check("reset empty", {31'd0, empty_a}, 32'd1);
        check("reset full", {31'd0, full_a}, 32'd0);
        check("reset sp_ctrl", {30'd0, spc_a}, 32'd0);
        check("reset req_ready", {31'd0, ba.req_ready}, 32'd1);
        check("reset strobes", {30'd0, we_a, re_a}, 32'd0);
        check("reset rsp_data", {24'd0, ba.rsp_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two pushes: stack grows downward from 127.
        issue(0, OP_PUSH, 8'hA5, 0, 8'h00, "push A5");
        check("push A5 addr", {24'd0, addr_a}, 32'd127);
        check("push A5 wdata", {24'd0, wdata_a}, 32'hA5);
        check("push A5 we", {31'd0, we_a}, 32'd1);
        check("push A5 sp_ctrl", {30'd0, spc_a}, 32'd3);
        check("push A5 ready low", {31'd0, ba.req_ready}, 32'd0);
        @(negedge clk);
        check("after push A5 sp", {24'd0, sp_a}, 32'd127);
        check("after push A5 sp_ctrl", {30'd0, spc_a}, 32'd0);
        check("ram[127]", {24'd0, ram_a[127]}, 32'hA5);
        issue(0, OP_PUSH, 8'h3C, 0, 8'h00, "push 3C");
        check("push 3C addr", {24'd0, addr_a}, 32'd126);
        check("push 3C sp_ctrl", {30'd0, spc_a}, 32'd3);
        @(negedge clk);
        check("after push 3C sp", {24'd0, sp_a}, 32'd126);

        // Peek leaves sp; pops return in LIFO order.
        issue(0, OP_PEEK, 8'h00, 0, 8'h3C, "peek");
        check("peek re", {31'd0, re_a}, 32'd1);
        check("peek addr", {24'd0, addr_a}, 32'd126);
        check("peek sp_ctrl", {30'd0, spc_a}, 32'd0);
        @(negedge clk);
        check("after peek sp", {24'd0, sp_a}, 32'd126);
        issue(0, OP_POP, 8'h00, 0, 8'h3C, "pop 3C");
        check("pop 3C sp_ctrl", {30'd0, spc_a}, 32'd2);
        check("pop 3C addr", {24'd0, addr_a}, 32'd126);
        @(negedge clk);
        check("after pop 3C sp", {24'd0, sp_a}, 32'd127);
        issue(0, OP_POP, 8'h00, 0, 8'hA5, "pop A5");
        check("pop A5 sp_ctrl", {30'd0, spc_a}, 32'd2);
        check("pop A5 addr", {24'd0, addr_a}, 32'd127);
        @(negedge clk);
        check("after pops sp", {24'd0, sp_a}, 32'd128);
        check("after pops empty", {31'd0, empty_a}, 32'd1);
        @(negedge clk);
        check("rsp_data hold", {24'd0, ba.rsp_data}, 32'hA5);

        // Underflow.
        issue(0, OP_POP, 8'h00, 1, 8'h00, "pop empty");
        check("pop empty strobes", {30'd0, we_a, re_a}, 32'd0);
        check("pop empty sp_ctrl", {30'd0, spc_a}, 32'd0);
        @(negedge clk);
        check("pop empty sp", {24'd0, sp_a}, 32'd128);

        // Reset during the PUSH cycle drops the write and the response.
        ba.req_valid = 1'b1; ba.req_op = OP_PUSH; ba.req_data = 8'h77;
        @(posedge clk);
        #1;
        ba.req_valid = 1'b0;
        check("midreset we before", {31'd0, we_a}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset we dropped", {31'd0, we_a}, 32'd0);
        check("midreset sp", {24'd0, sp_a}, 32'd128);
        check("midreset rsp_valid", {31'd0, ba.rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midreset ram[127] kept", {24'd0, ram_a[127]}, 32'hA5);
        issue(0, OP_PUSH, 8'h11, 0, 8'h00, "push after reset");
        check("push after reset addr", {24'd0, addr_a}, 32'd127);
        @(negedge clk);
        check("push after reset ram", {24'd0, ram_a[127]}, 32'h11);

        // Small stack: fill, overflow, clear.
        for (int i = 0; i < 4; i++) begin
            issue(1, OP_PUSH, N'(8'h10 + i), 0, 8'h00, "b push");
            @(negedge clk);
        end
        check("b full", {31'd0, full_b}, 32'd1);
        check("b full sp", {24'd0, sp_b}, 32'd0);
        check("b full not empty", {31'd0, empty_b}, 32'd0);
        check("b ram[0]", {24'd0, ram_b[0]}, 32'h13);
        check("b ram[3]", {24'd0, ram_b[3]}, 32'h10);
        issue(1, OP_PUSH, 8'h99, 1, 8'h00, "b push full");
        check("b overflow we", {31'd0, we_b}, 32'd0);
        check("b overflow sp_ctrl", {30'd0, spc_b}, 32'd0);
        @(negedge clk);
        check("b overflow sp", {24'd0, sp_b}, 32'd0);
        issue(1, OP_CLEAR, 8'h00, 0, 8'h00, "b clear");
        check("b clear sp_ctrl", {30'd0, spc_b}, 32'd1);
        @(negedge clk);
        check("b clear sp", {24'd0, sp_b}, 32'd4);
        check("b clear empty", {31'd0, empty_b}, 32'd1);
`ifdef STACK_WATERMARK_EN
        check("b max_depth", {24'd0, maxd_b}, 32'd4);
        check("a max_depth", {24'd0, maxd_a}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        check("a scoreboard drained", q_a.size(), 32'd0);
        check("b scoreboard drained", q_b.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Push/pop sequencer that drives the stack-pointer control code and the data-memory stack port.
- Takes push, pop, peek and clear commands from the control unit over a valid/ready handshake.
- Keeps an internal SP copy that matches the external SP register.
- Sequences synchronous-RAM writes and reads, and returns popped data with a response strobe.

Parameters:
- N, 8, address/data width and SP width
- SP_INIT, 128, SP reset/clear value; stack empty when sp==SP_INIT
- SP_LIMIT, 0, lowest legal SP; stack full when sp==SP_LIMIT

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  block can accept a command
- req_op  in  2  01 push, 10 pop, 11 clear, 00 peek
- req_data  in  N  push data
- rsp_valid  out  1  one-cycle response strobe
- rsp_err  out  1  with rsp_valid: overflow/underflow, command discarded
- rsp_data  out  N  pop/peek data, valid with rsp_valid
- sp_ctrl  out  2  SP code: 00 hold, 01 clear, 10 increment, 11 decrement
- sp  out  N  internal stack pointer
- full  out  1  sp==SP_LIMIT
- empty  out  1  sp==SP_INIT
- mem_addr  out  N  stack RAM address
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable; rdata valid the following cycle
- mem_wdata  out  N  RAM write data
- mem_rdata  in  N  RAM read data

Behaviour:
- Reset (async, any state): state=IDLE, sp=SP_INIT, sp_ctrl=00, mem_we=mem_re=0, rsp_valid=rsp_err=0, rsp_data=0, req_ready=1. An in-flight push is dropped with no write; an in-flight pop is dropped with no response.
- States:
  - IDLE: req_ready=1 only here. Accept on req_valid&&req_ready in cycle 0. req_op and req_data are captured.
  - PUSH (cycle 1, from an accepted push with !full): mem_addr=sp-1, mem_wdata=captured data, mem_we=1, sp_ctrl=11, sp<=sp-1 at end of cycle. rsp_valid=1, rsp_err=0 in the same cycle. Next state IDLE.
  - READ (cycle 1, from an accepted pop or peek with !empty): mem_addr=sp, mem_re=1. For pop: sp_ctrl=10, sp<=sp+1. For peek: sp_ctrl=00.
  - RESP (cycle 2): rsp_valid=1, rsp_data=mem_rdata, registered as of cycle 2 output. Next state IDLE.
  - ERR (cycle 1, push when full, or pop/peek when empty): no memory access, sp_ctrl=00, sp unchanged. rsp_valid=1, rsp_err=1. Next state IDLE.
  - CLR (cycle 1, from an accepted clear): sp_ctrl=01, sp<=SP_INIT, rsp_valid=1. Legal when empty.
- Latency: push, clear and error return 1 cycle after accept; pop and peek return 2 cycles after accept. Throughput is one command per 2 cycles for push and clear, and per 3 cycles for pop and peek.
- sp_ctrl is 00 in every cycle except PUSH, pop-READ and CLR. An external SP register updating on negedge tracks sp exactly.
- Arithmetic is N bits. SP never wraps, because full and empty block the crossing.
- Data order: stack grows downward. After SP_INIT-SP_LIMIT pushes, sp==SP_LIMIT and full=1.
- full and empty are combinational from sp. They are never both 1 while SP_INIT>SP_LIMIT.
- req_valid while busy is ignored (req_ready=0). The requester holds it.
- rsp_data holds its last value when rsp_valid=0.

Optional Feature:
- STACK_WATERMARK_EN defined:
  - Adds output max_depth [N-1:0], registered, reset 0.
  - After each push, updates to max(max_depth, SP_INIT-sp).
  - Clear does not reset it; only rst_n does.
- Undefined: port absent, no logic.

Test Plan:
- Reset then idle -> sp=128, empty=1, full=0, sp_ctrl=00, req_ready=1, no mem strobes.
- Push 0xA5, then push 0x3C -> writes addr 127=0xA5, then addr 126=0x3C. sp_ctrl=11 on each write cycle. sp=126. Each rsp_valid 1 cycle after accept.
- Peek, then pop, then pop -> peek returns 0x3C with sp=126. Pops return 0x3C, then 0xA5. sp_ctrl=10 on the pop READ cycles. Final sp=128, empty=1.
- Pop on empty -> rsp_valid=1, rsp_err=1 one cycle later. No mem_re. sp=128.
- Parameters SP_INIT=4, SP_LIMIT=0: four pushes -> full=1, sp=0. Fifth push -> rsp_err=1, no mem_we. Clear -> sp_ctrl=01 then sp=4. With STACK_WATERMARK_EN, max_depth=4 and stays 4 after clear.
- Assert rst_n low during the PUSH cycle -> mem_we drops immediately, sp=128, no rsp_valid. The next push after release writes addr 127.
